// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Provides the lookahead group size and group-level P/G helpers.
package cla_pkg;

  localparam int GROUP = 4;

  function automatic int group_count(input int width);
    return width / GROUP;
  endfunction

  // Group propagate: every bit of the group propagates.
  function automatic logic grp_prop(
    input logic [GROUP-1:0] p
  );
    return &p;
  endfunction

  // Group generate: the group produces a carry by itself.
  function automatic logic grp_gen(
    input logic [GROUP-1:0] p,
    input logic [GROUP-1:0] g
  );
    logic gen;
    gen = g[0];
    for (int i = 1; i < GROUP; i++) begin
      gen = g[i] | (p[i] & gen);
    end
    return gen;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit lookahead group: p/g/c_in -> grp_p, grp_g, s.
// Ports: p, g, c_in in; grp_p, grp_g, s out.
module cla_group4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       c_in,
  output logic       grp_p,
  output logic       grp_g,
  output logic [3:0] s
);

  logic [3:0] c;

  always_comb begin
    c[0] = c_in;
    c[1] = g[0]
         | (p[0] & c_in);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & c_in);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
  end

  assign grp_p = &p;
  assign grp_g = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

  assign s = p ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined CLA add/sub with valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_ready, a, b, c_in, sub, out_valid/out_ready, sum, c_out, ovf.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NG = group_count(WIDTH);

  // ---------------- stage 1 ----------------
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic [NG-1:0]    gp_in;
  logic [NG-1:0]    gg_in;

  // Subtract as a + ~b + ~c_in, so borrow-in becomes inverted carry-in.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? ~c_in : c_in;
  assign p_in  = a ^ b_eff;
  assign g_in  = a & b_eff;

  always_comb begin
    gp_in = '0;
    gg_in = '0;
    for (int k = 0; k < NG; k++) begin
      gp_in[k] = grp_prop(p_in[k*GROUP +: GROUP]);
      gg_in[k] = grp_gen(p_in[k*GROUP +: GROUP],
                         g_in[k*GROUP +: GROUP]);
    end
  end

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic [NG-1:0]    s1_gp;
  logic [NG-1:0]    s1_gg;
  logic             s1_c;

  logic s2_load;
  logic s1_load;

  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign s1_load  = ~s1_valid | s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_gp    <= '0;
      s1_gg    <= '0;
      s1_c     <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p  <= p_in;
        s1_g  <= g_in;
        s1_gp <= gp_in;
        s1_gg <= gg_in;
        s1_c  <= c_eff;
      end
    end
  end

  // ---------------- stage 2 ----------------
  // Second-level lookahead: carry into each group from stage-1 P/G.
  logic [NG-1:0] gc;

  always_comb begin
    logic cy;
    logic run;
    gc    = '0;
    gc[0] = s1_c;
    for (int k = 1; k < NG; k++) begin
      cy  = 1'b0;
      run = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        cy  = cy | (run & s1_gg[j]);
        run = run & s1_gp[j];
      end
      gc[k] = cy | (run & s1_c);
    end
  end

  logic [WIDTH-1:0] sum_d;
  logic [NG-1:0]    ip;
  logic [NG-1:0]    ig;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .p     (s1_p[k*GROUP +: GROUP]),
      .g     (s1_g[k*GROUP +: GROUP]),
      .c_in  (gc[k]),
      .grp_p (ip[k]),
      .grp_g (ig[k]),
      .s     (sum_d[k*GROUP +: GROUP])
    );
  end

  // Block carry-out: lookahead across all group P/G.
  logic c_out_d;
  logic ovf_d;
  logic c_msb;

  always_comb begin
    logic cy;
    logic run;
    cy  = 1'b0;
    run = 1'b1;
    for (int j = NG - 1; j >= 0; j--) begin
      cy  = cy | (run & ig[j]);
      run = run & ip[j];
    end
    c_out_d = cy | (run & s1_c);
  end

  // Carry into the MSB recovered as s ^ p at that bit.
  assign c_msb = sum_d[WIDTH-1] ^ s1_p[WIDTH-1];
  assign ovf_d = c_msb ^ c_out_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      sum       <= sum_d;
      c_out     <= c_out_d;
      ovf       <= ovf_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16).
// Directed vectors, backpressure, mid-run reset and a random soak.
module tb_cla_pipe_adder;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  cla_pipe_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W+1:0] exp_q[$];
  logic         acc;
  logic         ov_seen;
  logic         prev_stall;
  logic [W+1:0] prev_out;

  // Reference: plain integer arithmetic, result {sum, c_out, ovf}.
  function automatic logic [W+1:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         ci,
    input logic         s
  );
    longint ux;
    longint uy;
    longint sx;
    longint sy;
    longint r;
    longint sr;
    logic   co;
    logic   ov;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!s) begin
      r  = ux + uy + longint'(ci);
      co = (r >= 65536);
      sr = sx + sy + longint'(ci);
    end else begin
      r  = ux - uy - longint'(ci);
      co = (ux >= uy + longint'(ci));
      sr = sx - sy - longint'(ci);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {r[W-1:0], co, ov};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample at negedge, update model, land at posedge+1.
  task automatic tick();
    logic [W+1:0] e;
    @(negedge clk);
    ov_seen = out_valid;
    acc     = in_valid && in_ready;
    if (prev_stall)
      chk("hold", {14'd0, out_valid, sum, c_out, ovf},
                  {14'd0, 1'b1, prev_out});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", {14'd0, sum, c_out, ovf}, {14'd0, e});
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = {sum, c_out, ovf};
    if (acc) exp_q.push_back(model(a, b, c_in, sub));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic s);
    in_valid = 1'b1;
    a = x;
    b = y;
    c_in = ci;
    sub = s;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic s);
    int n;
    drive(x, y, ci, s);
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc && n < 20);
    if (!acc) chk("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    int idx;
    int nacc;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    a          = '0;
    b          = '0;
    c_in       = 1'b0;
    sub        = 1'b0;
    prev_stall = 1'b0;
    prev_out   = '0;
    acc        = 1'b0;
    ov_seen    = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {sum, c_out, ovf}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Carry ripple with latency measurement.
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tick();
    chk("lat_accept", acc, 1);
    in_valid = 1'b0;
    tick();
    chk("lat_c1_no_valid", ov_seen, 0);
    tick();
    chk("lat_c2_valid", ov_seen, 1);
    chk("ripple_direct", {sum, c_out, ovf}, {16'h0000, 1'b1, 1'b0});
    drain();

    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drain();
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    drain();
    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    drain();

    // Backpressure: 4 cycles of push with output stalled.
    out_ready = 1'b0;
    idx  = 1;
    nacc = 0;
    repeat (4) begin
      drive(16'(idx), 16'(idx * 3), 1'b0, 1'b0);
      tick();
      if (acc) begin
        nacc++;
        idx++;
      end
    end
    chk("bp_accepted", nacc, 2);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    nacc = 0;
    while (idx <= 4 && nacc < 20) begin
      drive(16'(idx), 16'(idx * 3), 1'b0, 1'b0);
      tick();
      nacc++;
      if (acc) idx++;
    end
    chk("bp_all_sent", idx, 5);
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    send(16'h4321, 16'h0101, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (5) begin
      tick();
      chk("post_rst_quiet", ov_seen, 0);
    end

    // Random soak.
    for (int i = 0; i < 20000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a    = 16'($urandom);
      b    = 16'($urandom);
      c_in = 1'($urandom);
      sub  = 1'($urandom);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
